spi_ram_responder: RTL
======================

# spi_ram_responder

Synthesizable SPI-mode-0 memory responder: the target end of the serial memory link that the CPU drives as initiator on `uio[0]` (CS_N), `uio[1]` (MOSI), `uio[2]` (MISO) and `uio[3]` (SCK). It replaces the behavioural RAM on-chip or on an FPGA carrier and exposes the same command set: READ `0x03`, plus WRITE `0x02` when configured. It uses a 16-bit big-endian address with auto-increment. All SPI inputs are oversampled by the system clock; no logic runs on SCK.

## Interface
- `ADDR_BITS`, default 8: memory depth is 2^ADDR_BITS bytes. Only the low ADDR_BITS of the 16-bit address are used.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `sck`  in  1  SPI clock, mode 0 (idle low), asynchronous to `clk`.
- `mosi`  in  1  serial data from the initiator, MSB first.
- `miso`  out  1  serial data to the initiator, MSB first.
- `miso_oe`  out  1  high while `miso` is being driven (read data phase only).
- `busy`  out  1  high from command start until the synchronized `cs_n` rises.
- `cmd_err`  out  1  one-`clk` pulse when an unsupported command byte completes.

## Operation
- **Input synchronization:** `cs_n`, `sck` and `mosi` each pass through a 2-flop synchronizer. SCK rising and falling edges are detected from the synchronized value and its previous value.
- **FSM states:** IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- **IDLE → CMD:** synchronized `cs_n` falls. Clear the bit counter and set `busy`.
- **CMD:** shift `mosi` in on each SCK rising edge. After 8 bits:
  - `0x03` → ADDR (read pending).
  - `0x02` → ADDR (write pending).
  - anything else → IGNORE, with a `cmd_err` pulse.
- **ADDR:** shift 16 bits MSB first, then latch the address register.
  - Read pending → READ: on the next SCK falling edge, load `mem[addr]` into the TX shift register and drive its MSB.
  - Write pending → WRITE.
- **READ:**
  - Shift TX out on each SCK falling edge.
  - After 8 bits, increment the address and load the next byte at the following falling edge.
  - `miso_oe` = 1 for the whole state.
- **WRITE:**
  - Shift RX in on each SCK rising edge.
  - On the 8th bit, write `mem[addr]` in that same `clk` cycle, then increment the address.
- **IGNORE:** consume SCK edges with no effect.
- **Address wrap:** increment is modulo 2^ADDR_BITS, so address 2^ADDR_BITS−1 is followed by 0.
- **Any state → IDLE:** synchronized `cs_n` rises. Clear `busy` and `miso_oe`, and drive `miso` = 0.
  - A partial write byte is discarded.
  - A partial command or address aborts the transaction with no side effects.
- **Simultaneous events:** a `cs_n` rise in the same `clk` cycle as an SCK edge is resolved in favour of the `cs_n` rise; that edge is ignored.
- **Memory contents:**
  - Memory is an internal flop array and is not reset.
  - Contents survive `rst_n`.
  - Simulation initial value is X unless preloaded hierarchically (`mem[i]`).

## Timing
- **Reset values:** `miso` = 0, `miso_oe` = 0, `busy` = 0, `cmd_err` = 0, FSM = IDLE, counters = 0.
- **Input latency:** 3 `clk` cycles from an SPI pin change to internal action (2 synchronizer stages plus 1 edge-detect stage).
- **SCK constraint:** SCK high and low phases must each be ≥ 4 `clk` periods. Equivalently, f_SCK ≤ f_clk/8.
- **CS_N setup:** `cs_n` falling to the first SCK rise must be ≥ 4 `clk` periods.
- **MISO valid:** `miso` changes 3 `clk` after SCK falls. It is stable before the next SCK rise, given the SCK constraint.
- **First read data:** MSB of byte 0 is valid before the 25th SCK rising edge (the edge after the last address bit).
- **Write visibility:** a written byte is readable by any later transaction, including one started 1 `clk` after the synchronized `cs_n` rises.
- **Reset mid-transaction:** outputs go to their reset values immediately (asynchronously). The block ignores further SCK activity until the next synchronized `cs_n` falling edge.

## Configuration
- `SPI_RAM_WRITE_EN` defined: WRITE `0x02` is supported as described under Operation.
- `SPI_RAM_WRITE_EN` undefined:
  - `0x02` is treated as unsupported (IGNORE plus a `cmd_err` pulse).
  - The write path and WRITE state are not synthesized.
  - Memory is read-only and can only be preloaded in simulation.

## Test plan
- **Reset check:** hold `rst_n` = 0 for 5 `clk` cycles → `miso` = 0, `miso_oe` = 0, `busy` = 0, `cmd_err` = 0.
- **Write then read (WRITE_EN on):** WRITE `0x02`, address `0x0010`, data `0xA5`, `0x3C`; raise `cs_n`; READ `0x03` at `0x0010` for 2 bytes → MISO returns `0xA5` then `0x3C`, and `miso_oe` = 1 only during the data phase.
- **Wrap-around (ADDR_BITS = 8):**
  - Preload `mem[0xFF]` = `0x11` and `mem[0x00]` = `0x22`.
  - READ at `0x00FF` for 2 bytes → MISO returns `0x11` then `0x22`.
- **Unsupported command:** send `0x9F` → exactly one `cmd_err` pulse, `miso_oe` stays 0, memory unchanged. With `SPI_RAM_WRITE_EN` undefined, sending `0x02` gives the same response.
- **Aborted write:** WRITE at `0x0020` (preloaded `0x55`); raise `cs_n` after 5 data bits → `mem[0x20]` stays `0x55`. A following READ at `0x0020` returns `0x55`.
- **Reset mid-read:** assert `rst_n` during byte 1 of a READ → outputs take their reset values immediately. After release, a fresh READ at `0x0000` returns the correct byte.

Source files
------------

// File: rtl/spi_ram_responder.sv
// spi_ram_responder
//   SPI mode-0 target that serves a small byte memory to an SPI initiator.
//   Commands: READ 0x03 and, when SPI_RAM_WRITE_EN is defined, WRITE 0x02.
//   The 16-bit big-endian address uses only its low ADDR_BITS bits and
//   auto-increments with wrap.
//   All SPI pins are oversampled by clk; nothing is clocked by sck.
//
//   Optional feature macro: SPI_RAM_WRITE_EN.
//   When it is undefined, 0x02 is an unsupported command and the memory is
//   read-only (preloaded hierarchically in simulation).
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   cs_n     SPI chip select, active low (asynchronous to clk)
//   sck      SPI clock, mode 0 (asynchronous to clk)
//   mosi     serial data in, MSB first
//   miso     serial data out, MSB first
//   miso_oe  high while miso is driven (READ data phase)
//   busy     high from command start until the synchronized cs_n rises
//   cmd_err  one-clk pulse when an unsupported command byte completes
module spi_ram_responder #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs_n,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
`ifdef SPI_RAM_WRITE_EN
    S_WRITE,
`endif
    S_IGNORE
  } state_t;

  logic [7:0] mem [0:DEPTH-1];

  // Synchronizers and edge-detect history.
  // cs_n resets low so that releasing reset with cs_n already low does not
  // look like a new falling edge; the block then waits for a real one.
  logic [1:0] cs_sync, sck_sync, mosi_sync;
  logic       cs_prev, sck_prev;
  logic       cs_s, sck_s, mosi_s;
  logic       cs_fall, cs_rise, sck_rise, sck_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_prev   <= cs_sync[1];
      sck_prev  <= sck_sync[1];
    end
  end

  assign cs_s     = cs_sync[1];
  assign sck_s    = sck_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [14:0] sr, sr_n;          // command / address / write-data shifter
  addr_t      addr, addr_n;
  logic [7:0] tx, tx_n;
  logic       miso_q, miso_n;
  logic       cmd_err_q, cmd_err_n;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] cmd_byte;
  logic [7:0] mem_rd;
`ifdef SPI_RAM_WRITE_EN
  logic       wr_pend, wr_pend_n;
`endif

  assign cmd_byte = {sr[6:0], mosi_s};
  assign mem_rd   = mem[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      addr      <= '0;
      tx        <= '0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef SPI_RAM_WRITE_EN
      wr_pend   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      sr        <= sr_n;
      addr      <= addr_n;
      tx        <= tx_n;
      miso_q    <= miso_n;
      cmd_err_q <= cmd_err_n;
`ifdef SPI_RAM_WRITE_EN
      wr_pend   <= wr_pend_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    addr_n    = addr;
    tx_n      = tx;
    miso_n    = miso_q;
    cmd_err_n = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
`ifdef SPI_RAM_WRITE_EN
    wr_pend_n = wr_pend;
`endif
    // A cs_n rise wins over any SCK edge seen in the same cycle.
    if (cs_rise) begin
      state_n   = S_IDLE;
      bit_cnt_n = '0;
      miso_n    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state_n   = S_CMD;
            bit_cnt_n = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sr_n      = {sr[13:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (cmd_byte == 8'h03) begin
                state_n = S_ADDR;
`ifdef SPI_RAM_WRITE_EN
                wr_pend_n = 1'b0;
              end else if (cmd_byte == 8'h02) begin
                state_n   = S_ADDR;
                wr_pend_n = 1'b1;
`endif
              end else begin
                state_n   = S_IGNORE;
                cmd_err_n = 1'b1;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sr_n      = {sr[13:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt_n = '0;
              addr_n    = addr_t'({sr, mosi_s});
              state_n   = S_READ;
`ifdef SPI_RAM_WRITE_EN
              if (wr_pend) state_n = S_WRITE;
`endif
            end
          end
        end
        S_READ: begin
          // bit_cnt == 0 means a fresh byte must be fetched on this fall.
          if (sck_fall) begin
            if (bit_cnt == 4'd0) begin
              miso_n    = mem_rd[7];
              tx_n      = {mem_rd[6:0], 1'b0};
              bit_cnt_n = 4'd1;
            end else begin
              miso_n = tx[7];
              tx_n   = {tx[6:0], 1'b0};
              if (bit_cnt == 4'd7) begin
                bit_cnt_n = '0;
                addr_n    = addr + addr_t'(1);
              end else begin
                bit_cnt_n = bit_cnt + 4'd1;
              end
            end
          end
        end
`ifdef SPI_RAM_WRITE_EN
        S_WRITE: begin
          if (sck_rise) begin
            sr_n      = {sr[13:0], mosi_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              mem_we    = 1'b1;
              mem_wdata = cmd_byte;
              addr_n    = addr + addr_t'(1);
            end
          end
        end
`endif
        S_IGNORE: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  assign miso    = miso_q;
  assign miso_oe = (state == S_READ);
  assign busy    = (state != S_IDLE);
  assign cmd_err = cmd_err_q;

endmodule
